// File: rtl/mult_pkg.sv
// Shared definitions for the multiply-issue controller: op codes, FSM states
// and operand-width helpers derived from pN.
package mult_pkg;

    localparam int PN_DEF = 2;
    localparam int W_DEF  = 2 ** PN_DEF;
    localparam int W2_DEF = 2 * W_DEF;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_MFHI  = 2'd2,
        OP_MFLO  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    function automatic int op_width(input int pn);
        return 2 ** pn;
    endfunction

endpackage

// File: rtl/mult_issue_ctrl_if.sv
// EX-side request bus and multiplier handshake bundled together.
// master = EX stage / multiplier side, slave = the issue controller.
interface mult_issue_ctrl_if #(parameter int pN = mult_pkg::PN_DEF);

    localparam int W = 2 ** pN;

    logic             Req_Valid;
    logic [1:0]       Req_Op;
    logic [W-1:0]     Req_A;
    logic [W-1:0]     Req_B;
    logic             Stall;
    logic [W-1:0]     Rd_Data;
    logic             Mul_Ld;
    logic [W-1:0]     Mul_M;
    logic [W-1:0]     Mul_R;
    logic             Mul_Valid;
    logic [2*W-1:0]   Mul_P;
    logic [W-1:0]     Hi;
    logic [W-1:0]     Lo;

    modport master (
        output Req_Valid, Req_Op, Req_A, Req_B, Mul_Valid, Mul_P,
        input  Stall, Rd_Data, Mul_Ld, Mul_M, Mul_R, Hi, Lo
    );

    modport slave (
        input  Req_Valid, Req_Op, Req_A, Req_B, Mul_Valid, Mul_P,
        output Stall, Rd_Data, Mul_Ld, Mul_M, Mul_R, Hi, Lo
    );

endinterface

// File: rtl/mult_hilo_fix.sv
// Combinational product fix-up: the multiplier is always signed, so MULTU adds
// back the operand-MSB weights before the HI/LO split.
module mult_hilo_fix
    import mult_pkg::*;
#(
    parameter int pN = PN_DEF
)
(
    input  logic [2*op_width(pN)-1:0] p,
    input  logic [op_width(pN)-1:0]   a,
    input  logic [op_width(pN)-1:0]   b,
    input  logic                      is_unsigned,
    output logic [op_width(pN)-1:0]   hi,
    output logic [op_width(pN)-1:0]   lo
);

    localparam int W = op_width(pN);

    logic [2*W-1:0] corr_a;
    logic [2*W-1:0] corr_b;
    logic [2*W-1:0] r;

    // A negative signed view of an operand is short by 2^W times the other one.
    assign corr_a = a[W-1] ? {b, {W{1'b0}}} : '0;
    assign corr_b = b[W-1] ? {a, {W{1'b0}}} : '0;
    assign r      = is_unsigned ? (p + corr_a + corr_b) : p;

    assign hi = r[2*W-1:W];
    assign lo = r[W-1:0];

endmodule

// File: rtl/mult_issue_ctrl.sv
// Multiply-issue controller between EX and the Booth multiplier; owns HI/LO.
// Optional build macro MULT_ZERO_BYPASS_EN commits zero-operand multiplies in one cycle.
//
// state  | meaning
// S_IDLE | accepting requests, MFHI/MFLO served combinationally
// S_LOAD | Mul_Ld pulse with captured operands
// S_WAIT | waiting for a fresh rising Mul_Valid
// S_FIX  | sign correction and HI/LO commit
module mult_issue_ctrl
    import mult_pkg::*;
#(
    parameter int pN = PN_DEF
)
(
    input  logic              Clk,
    input  logic              Rst,
    mult_issue_ctrl_if.slave  bus
);

    localparam int W = op_width(pN);

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            unsigned_q;
    logic [2*W-1:0]  p_q;
    logic            valid_q;
    logic            mul_ld_q;
    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;
    logic [W-1:0]    hi_fix;
    logic [W-1:0]    lo_fix;
    logic            req_mul;
    logic            zero_op;
    logic [W-1:0]    rd_data;

    assign req_mul = bus.Req_Valid && !bus.Req_Op[1];

`ifdef MULT_ZERO_BYPASS_EN
    assign zero_op = (bus.Req_A == '0) || (bus.Req_B == '0);
`else
    assign zero_op = 1'b0;
`endif

    mult_hilo_fix #(.pN(pN)) u_fix (
        .p           (p_q),
        .a           (a_q),
        .b           (b_q),
        .is_unsigned (unsigned_q),
        .hi          (hi_fix),
        .lo          (lo_fix)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            unsigned_q <= 1'b0;
            p_q        <= '0;
            valid_q    <= 1'b0;
            mul_ld_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_mul) begin
                        if (zero_op) begin
                            hi_q <= '0;
                            lo_q <= '0;
                        end else begin
                            a_q        <= bus.Req_A;
                            b_q        <= bus.Req_B;
                            unsigned_q <= bus.Req_Op[0];
                            mul_ld_q   <= 1'b1;
                            state      <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    mul_ld_q <= 1'b0;
                    valid_q  <= 1'b0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // Only a rising Valid counts; a level left over from the last op is ignored.
                    valid_q <= bus.Mul_Valid;
                    if (bus.Mul_Valid && !valid_q) begin
                        p_q   <= bus.Mul_P;
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi_q  <= hi_fix;
                    lo_q  <= lo_fix;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (bus.Req_Valid && (state == S_IDLE)) begin
            if (bus.Req_Op == OP_MFHI)
                rd_data = hi_q;
            else if (bus.Req_Op == OP_MFLO)
                rd_data = lo_q;
        end
    end

    assign bus.Stall   = bus.Req_Valid && (state != S_IDLE);
    assign bus.Rd_Data = rd_data;
    assign bus.Mul_Ld  = mul_ld_q;
    assign bus.Mul_M   = a_q;
    assign bus.Mul_R   = b_q;
    assign bus.Hi      = hi_q;
    assign bus.Lo      = lo_q;

endmodule
